// File: rtl/attn_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// attn_pkg : shared types, defaults and helpers for the attention datapath
// Revision : 1.0
// ----------------------------------------------------------------------------
package attn_pkg;

  localparam int c_DATA_WIDTH  = 16;
  localparam int c_FRAC_BITS   = 8;
  localparam int c_TOKEN_DIM   = 4;
  localparam int c_TOKEN_NUM   = 8;
  localparam int c_SCALE_SHIFT = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  function automatic int acc_width(input int data_w, input int dim);
    return 2 * data_w + $clog2(dim);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fxp_round_sat.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fxp_round_sat : round-half-up arithmetic right shift, then saturate to OUT_W
// Revision      : 1.0
// ----------------------------------------------------------------------------
module fxp_round_sat #(
  parameter int IN_W  = 34,
  parameter int OUT_W = 16,
  parameter int SHIFT = 8
) (
  input  logic signed [IN_W-1:0]  i_din,
  output logic signed [OUT_W-1:0] o_dout,
  output logic                    o_sat
);

  localparam logic signed [IN_W:0] c_MAX = {{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] c_MIN = {{(IN_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

  // One guard bit keeps the rounding add from wrapping at the positive limit.
  logic signed [IN_W:0] w_ext;
  logic signed [IN_W:0] w_rnd;
  logic signed [IN_W:0] w_shr;

  assign w_ext = {i_din[IN_W-1], i_din};

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [IN_W:0] c_HALF = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
      assign w_rnd = w_ext + c_HALF;
    end else begin : g_noround
      assign w_rnd = w_ext;
    end
  endgenerate

  assign w_shr = w_rnd >>> SHIFT;

  always_comb begin
    o_sat  = 1'b0;
    o_dout = w_shr[OUT_W-1:0];
    if (w_shr > c_MAX) begin
      o_sat  = 1'b1;
      o_dout = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (w_shr < c_MIN) begin
      o_sat  = 1'b1;
      o_dout = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end

endmodule
`default_nettype wire

// File: rtl/qk_score_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// qk_score_engine : S = (Q*K^T) >> SCALE_SHIFT with one time-shared signed MAC
// Revision        : 1.0
// ----------------------------------------------------------------------------
module qk_score_engine
  import attn_pkg::*;
#(
  parameter int DATA_WIDTH  = c_DATA_WIDTH,
  parameter int FRAC_BITS   = c_FRAC_BITS,
  parameter int TOKEN_DIM   = c_TOKEN_DIM,
  parameter int TOKEN_NUM   = c_TOKEN_NUM,
  parameter int SCALE_SHIFT = c_SCALE_SHIFT
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] Q,
  input  logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] K,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      s_valid,
  input  logic                                      s_ready,
  output logic [DATA_WIDTH-1:0]                     s_data,
  output logic [$clog2(TOKEN_NUM)-1:0]              s_row,
  output logic [$clog2(TOKEN_NUM)-1:0]              s_col,
  output logic                                      s_last,
  output logic                                      sat_flag
);

  localparam int ACC_W = acc_width(DATA_WIDTH, TOKEN_DIM);
  localparam int IDX_W = $clog2(TOKEN_NUM);
  localparam int K_W   = $clog2(TOKEN_DIM);
  localparam int VEC_W = DATA_WIDTH * TOKEN_DIM * TOKEN_NUM;
  localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(TOKEN_NUM - 1);
  localparam logic [K_W-1:0]   c_K_LAST   = K_W'(TOKEN_DIM - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [VEC_W-1:0]        r_q;
  logic [VEC_W-1:0]        r_k;
  logic [IDX_W-1:0]        r_row;
  logic [IDX_W-1:0]        r_col;
  logic [K_W-1:0]          r_kidx;
  logic signed [ACC_W-1:0] r_acc;
  logic [DATA_WIDTH-1:0]   r_s_data;
  logic                    r_done;
  logic                    r_sat;

  logic                           w_launch;
  logic                           w_mac_end;
  logic                           w_hs;
  logic                           w_last;
  logic                           w_sat;
  logic signed [DATA_WIDTH-1:0]   w_q_op;
  logic signed [DATA_WIDTH-1:0]   w_k_op;
  logic signed [DATA_WIDTH-1:0]   w_res;
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [ACC_W-1:0]        w_acc_nxt;
  logic [DATA_WIDTH-1:0]          w_q_arr [TOKEN_NUM][TOKEN_DIM];
  logic [DATA_WIDTH-1:0]          w_k_arr [TOKEN_NUM][TOKEN_DIM];

  generate
    for (genvar t = 0; t < TOKEN_NUM; t++) begin : g_tok
      for (genvar d = 0; d < TOKEN_DIM; d++) begin : g_dim
        assign w_q_arr[t][d] = r_q[(t*TOKEN_DIM+d)*DATA_WIDTH +: DATA_WIDTH];
        assign w_k_arr[t][d] = r_k[(t*TOKEN_DIM+d)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  endgenerate

  assign w_q_op    = w_q_arr[r_row][r_kidx];
  assign w_k_op    = w_k_arr[r_col][r_kidx];
  assign w_prod    = w_q_op * w_k_op;
  assign w_acc_nxt = r_acc + {{(ACC_W-2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};

  // The final product is folded in combinationally so the score registers on the last MAC cycle.
  fxp_round_sat #(
    .IN_W  (ACC_W),
    .OUT_W (DATA_WIDTH),
    .SHIFT (FRAC_BITS + SCALE_SHIFT)
  ) u_round_sat (
    .i_din  (w_acc_nxt),
    .o_dout (w_res),
    .o_sat  (w_sat)
  );

  assign w_launch  = (r_state == ST_IDLE) && start;
  assign w_mac_end = (r_state == ST_MAC) && (r_kidx == c_K_LAST);
  assign w_hs      = (r_state == ST_EMIT) && s_ready;
  assign w_last    = (r_row == c_IDX_LAST) && (r_col == c_IDX_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start)     w_state_nxt = ST_MAC;
      ST_MAC:  if (w_mac_end) w_state_nxt = ST_EMIT;
      ST_EMIT: if (s_ready)   w_state_nxt = w_last ? ST_IDLE : ST_MAC;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q      <= '0;
      r_k      <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_kidx   <= '0;
      r_acc    <= '0;
      r_s_data <= '0;
      r_done   <= 1'b0;
      r_sat    <= 1'b0;
    end else begin
      r_done <= w_hs && w_last;
      if (w_launch) begin
        r_q    <= Q;
        r_k    <= K;
        r_row  <= '0;
        r_col  <= '0;
        r_kidx <= '0;
        r_acc  <= '0;
        r_sat  <= 1'b0;
      end
      if (r_state == ST_MAC) begin
        r_acc <= w_acc_nxt;
        if (w_mac_end) begin
          r_kidx   <= '0;
          r_s_data <= w_res;
          r_sat    <= r_sat | w_sat;
        end else begin
          r_kidx <= r_kidx + 1'b1;
        end
      end
      if (w_hs) begin
        r_acc  <= '0;
        r_kidx <= '0;
        if (r_col == c_IDX_LAST) begin
          r_col <= '0;
          r_row <= w_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;
  assign s_valid  = (r_state == ST_EMIT);
  assign s_data   = r_s_data;
  assign s_row    = r_row;
  assign s_col    = r_col;
  assign s_last   = s_valid && w_last;
  assign sat_flag = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_qk_score_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_qk_score_engine : scoreboard bench, default engine plus an 8-dim/4-token engine
// Revision           : 1.0
// ----------------------------------------------------------------------------
module tb_qk_score_engine;

  localparam int DW  = 16;
  localparam int TD  = 4;
  localparam int TN  = 8;
  localparam int VW  = DW * TD * TN;
  localparam int TD6 = 8;
  localparam int TN6 = 4;
  localparam int VW6 = DW * TD6 * TN6;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  row;
    logic [2:0]  col;
    logic        last;
  } exp_t;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  row;
    logic [1:0]  col;
    logic        last;
  } exp6_t;

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic          start   = 1'b0;
  logic          s_ready = 1'b1;
  logic [VW-1:0] Q       = '0;
  logic [VW-1:0] K       = '0;
  logic          busy, done, s_valid, s_last, sat_flag;
  logic [15:0]   s_data;
  logic [2:0]    s_row, s_col;

  logic           start6   = 1'b0;
  logic           s_ready6 = 1'b1;
  logic [VW6-1:0] Q6       = '0;
  logic [VW6-1:0] K6       = '0;
  logic           busy6, done6, s_valid6, s_last6, sat6;
  logic [15:0]    s_data6;
  logic [1:0]     s_row6, s_col6;

  qk_score_engine dut (
    .clk(clk), .rst(rst), .start(start), .Q(Q), .K(K),
    .busy(busy), .done(done), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_row(s_row), .s_col(s_col), .s_last(s_last),
    .sat_flag(sat_flag)
  );

  qk_score_engine #(
    .DATA_WIDTH(16), .FRAC_BITS(8), .TOKEN_DIM(TD6), .TOKEN_NUM(TN6), .SCALE_SHIFT(1)
  ) dut6 (
    .clk(clk), .rst(rst), .start(start6), .Q(Q6), .K(K6),
    .busy(busy6), .done(done6), .s_valid(s_valid6), .s_ready(s_ready6),
    .s_data(s_data6), .s_row(s_row6), .s_col(s_col6), .s_last(s_last6),
    .sat_flag(sat6)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    errors = 0;
  int    checks = 0;
  exp_t  sb[$];
  exp6_t sb6[$];
  exp_t  mon_e;
  exp6_t mon_e6;
  int    t_start, first_valid, last_hs, hs_cnt, done_cnt, done_cyc;
  int    t6, first6, last6, hs6, dcnt6, dcyc6;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    errors++;
    checks++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  // Scoreboard monitors: pop one expected score per handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (s_valid && first_valid < 0) first_valid = cyc;
      if (s_valid && s_ready) begin
        hs_cnt++;
        last_hs = cyc;
        if (sb.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_score: got (%0d,%0d) required none", s_row, s_col);
        end else begin
          mon_e = sb.pop_front();
          chk("s_data", 32'(s_data), 32'(mon_e.data));
          chk("s_row",  32'(s_row),  32'(mon_e.row));
          chk("s_col",  32'(s_col),  32'(mon_e.col));
          chk("s_last", 32'(s_last), 32'(mon_e.last));
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_with_done", 32'(busy), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (s_valid6 && first6 < 0) first6 = cyc;
      if (s_valid6 && s_ready6) begin
        hs6++;
        last6 = cyc;
        if (sb6.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_score6: got (%0d,%0d) required none", s_row6, s_col6);
        end else begin
          mon_e6 = sb6.pop_front();
          chk("s_data6", 32'(s_data6), 32'(mon_e6.data));
          chk("s_pos6",  32'({s_row6, s_col6, s_last6}), 32'({mon_e6.row, mon_e6.col, mon_e6.last}));
        end
      end
      if (done6) begin
        dcnt6++;
        dcyc6 = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [15:0] qv, input logic [15:0] kv);
    for (int i = 0; i < TD*TN; i++) begin
      Q[i*DW +: DW] = qv;
      K[i*DW +: DW] = kv;
    end
  endtask

  // Expected score table: v00 at (0,0), v everywhere else.
  task automatic push_scores(input logic [15:0] v00, input logic [15:0] v);
    exp_t x;
    for (int r = 0; r < TN; r++) begin
      for (int c = 0; c < TN; c++) begin
        x.data = (r == 0 && c == 0) ? v00 : v;
        x.row  = 3'(r);
        x.col  = 3'(c);
        x.last = (r == TN-1) && (c == TN-1);
        sb.push_back(x);
      end
    end
  endtask

  task automatic launch();
    tick();
    first_valid = -1;
    last_hs     = -1;
    hs_cnt      = 0;
    done_cnt    = 0;
    done_cyc    = -1;
    start       = 1'b1;
    t_start     = cyc;
    tick();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt == 0) timeout_fail("done_wait");
    repeat (4) tick();
  endtask

  // Default config: first score at +5, last handshake at +320, done at +321.
  task automatic check_run(input int extra);
    chk("first_valid_latency", 32'(first_valid - t_start), 32'd5);
    chk("last_handshake_cycle", 32'(last_hs - t_start), 32'(320 + extra));
    chk("done_cycle", 32'(done_cyc - t_start), 32'(321 + extra));
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("score_count", 32'(hs_cnt), 32'd64);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t_rel;
    exp6_t y;

    repeat (3) tick();
    chk("reset_outputs", 32'({busy, done, s_valid, s_data, s_row, s_col, s_last, sat_flag}), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // All 1.0: each score is 4.0
    fill(16'h0100, 16'h0100);
    push_scores(16'h0400, 16'h0400);
    launch();
    wait_done(400);
    check_run(0);
    chk("t1_sat_flag", 32'(sat_flag), 32'd0);

    // Rounding half-up on a single product
    fill(16'h0000, 16'h0000);
    Q[15:0] = 16'h0001;
    K[15:0] = 16'h0080;
    push_scores(16'h0001, 16'h0000);
    launch();
    wait_done(400);
    check_run(0);

    fill(16'h0000, 16'h0000);
    Q[15:0] = 16'hFFFF;
    K[15:0] = 16'h0080;
    push_scores(16'h0000, 16'h0000);
    launch();
    wait_done(400);
    check_run(0);

    // Saturation both ways, then a clean launch clears the sticky flag
    fill(16'h7FFF, 16'h7FFF);
    push_scores(16'h7FFF, 16'h7FFF);
    launch();
    wait_done(400);
    check_run(0);
    chk("sat_set_pos", 32'(sat_flag), 32'd1);

    fill(16'h8000, 16'h7FFF);
    push_scores(16'h8000, 16'h8000);
    launch();
    wait_done(400);
    check_run(0);
    chk("sat_set_neg", 32'(sat_flag), 32'd1);

    fill(16'h0100, 16'h0100);
    push_scores(16'h0400, 16'h0400);
    launch();
    chk("sat_cleared_on_start", 32'(sat_flag), 32'd0);
    wait_done(400);
    check_run(0);

    // Backpressure: hold (2,3) for 10 cycles
    push_scores(16'h0400, 16'h0400);
    launch();
    n = 0;
    while (!(s_row == 3'd2 && s_col == 3'd3 && !s_valid) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) timeout_fail("bp_reach_2_3");
    s_ready = 1'b0;
    n = 0;
    while (!s_valid && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) timeout_fail("bp_valid");
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", 32'({s_valid, s_row, s_col, s_data}), 32'({1'b1, 3'd2, 3'd3, 16'h0400}));
      tick();
    end
    s_ready = 1'b1;
    t_rel   = cyc;
    tick();
    n = 0;
    while (!s_valid && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) timeout_fail("bp_next_valid");
    chk("bp_next_gap", 32'(cyc - t_rel), 32'd5);
    wait_done(400);
    check_run(10);

    // start while busy is ignored; Q/K changes after launch have no effect
    fill(16'h0100, 16'h0100);
    push_scores(16'h0400, 16'h0400);
    launch();
    repeat (50) tick();
    start = 1'b1;
    fill(16'h0000, 16'h0000);
    tick();
    start = 1'b0;
    wait_done(400);
    check_run(0);

    // Asynchronous reset mid-stream after 20 scores
    fill(16'h0100, 16'h0100);
    push_scores(16'h0400, 16'h0400);
    launch();
    n = 0;
    while (hs_cnt < 20 && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) timeout_fail("midrst_reach_20");
    rst = 1'b1;
    #1;
    chk("midrst_outputs", 32'({busy, done, s_valid, s_data, s_row, s_col, s_last, sat_flag}), 32'd0);
    sb.delete();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    push_scores(16'h0400, 16'h0400);
    launch();
    wait_done(400);
    check_run(0);

    // SCALE_SHIFT=1, 8-dim, 4 tokens, all 1.0: 8.0/2 = 4.0, period 9
    for (int i = 0; i < TD6*TN6; i++) begin
      Q6[i*DW +: DW] = 16'h0100;
      K6[i*DW +: DW] = 16'h0100;
    end
    for (int r = 0; r < TN6; r++) begin
      for (int c = 0; c < TN6; c++) begin
        y.data = 16'h0400;
        y.row  = 2'(r);
        y.col  = 2'(c);
        y.last = (r == TN6-1) && (c == TN6-1);
        sb6.push_back(y);
      end
    end
    tick();
    first6 = -1;
    last6  = -1;
    hs6    = 0;
    dcnt6  = 0;
    dcyc6  = -1;
    start6 = 1'b1;
    t6     = cyc;
    tick();
    start6 = 1'b0;
    n = 0;
    while (dcnt6 == 0 && n < 300) begin
      tick();
      n++;
    end
    if (dcnt6 == 0) timeout_fail("done6_wait");
    repeat (4) tick();
    chk("cfg6_first_valid", 32'(first6 - t6), 32'd9);
    chk("cfg6_last_handshake", 32'(last6 - t6), 32'd144);
    chk("cfg6_done_cycle", 32'(dcyc6 - t6), 32'd145);
    chk("cfg6_done_pulses", 32'(dcnt6), 32'd1);
    chk("cfg6_score_count", 32'(hs6), 32'd16);
    chk("cfg6_sat_flag", 32'(sat6), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/qk_score_engine.md
# qk_score_engine

Sequential, parametrised score engine for the attention datapath. Computes S = (Q·Kᵀ) >> SCALE_SHIFT with one time-shared signed MAC instead of a fully parallel array, using signed fixed-point with rounding and saturation. Sits upstream of the softmax stage, which receives one score per valid/ready handshake. Generalises the fixed Q8.8, fixed-size stage-1 product to arbitrary width, fraction, dimension and token count, and adds backpressure.

## Interface
- DATA_WIDTH, 16, element width, signed two's complement
- FRAC_BITS, 8, fractional bits of Q, K and S
- TOKEN_DIM, 4, elements per token (dot-product length)
- TOKEN_NUM, 8, tokens per matrix
- SCALE_SHIFT, 0, extra right shift approximating 1/sqrt(d)
- Reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  launch request, honoured only in IDLE
- Q  in  DATA_WIDTH*TOKEN_DIM*TOKEN_NUM  flat, element (t,d) at slice t*TOKEN_DIM+d
- K  in  same  same packing as Q
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last score is accepted
- s_valid  out  1  score available
- s_ready  in  1  consumer accepts
- s_data  out  DATA_WIDTH  score S[row][col]
- s_row, s_col  out  clog2(TOKEN_NUM)  score coordinates
- s_last  out  1  high with the final score (row = col = TOKEN_NUM-1)
- sat_flag  out  1  sticky; set if any score saturated, cleared on an accepted start

## Operation
- FSM states: IDLE, MAC, EMIT.
- IDLE: start=1 latches Q and K into internal registers, sets row=col=k=0, clears acc and sat_flag, and moves to MAC.
- MAC: acc += Q[row][k]*K[col][k], signed. acc width is ACC_W = 2*DATA_WIDTH + clog2(TOKEN_DIM).
  - k counts 0..TOKEN_DIM-1. After k=TOKEN_DIM-1 the FSM registers the result into s_data and moves to EMIT.
- Result: shift = FRAC_BITS + SCALE_SHIFT. Round half-up: (acc + 2^(shift-1)) >>> shift, arithmetic. Then saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. Saturation sets sat_flag.
- EMIT: s_valid=1. s_data, s_row, s_col and s_last stay stable until s_valid & s_ready.
  - On handshake, col increments. At col wrap, col=0 and row increments. acc and k clear, and the FSM returns to MAC.
  - On handshake with s_last=1, the FSM goes to IDLE and done pulses in the next cycle.
- start while busy is ignored. Q and K changes after launch have no effect.
- Reset (any time, including mid-operation): FSM goes to IDLE.
  - All outputs 0: busy, done, s_valid, s_data, s_row, s_col, s_last, sat_flag.
  - Counters and acc are 0.

## Timing
- start sampled in cycle 0. MAC runs cycles 1..TOKEN_DIM. The first s_valid is high in cycle TOKEN_DIM+1.
- With s_ready held at 1: one score per TOKEN_DIM+1 cycles. Total TOKEN_NUM²·(TOKEN_DIM+1) cycles from start to the last handshake. done follows one cycle after that handshake.
- s_valid never depends combinationally on s_ready. Under backpressure there is no MAC progress.
- busy rises the cycle after an accepted start and falls in the same cycle done pulses.

## Structure
- Package attn_pkg holds:
  - the FSM state enum
  - the ACC_W calculation function
  - the default-parameter constants shared with the softmax and AV stages
- Sub-module fxp_round_sat (params IN_W, OUT_W, SHIFT) is combinational and implements the round-half-up shift plus saturate, with a sat output. It is reused by the later stages.
- Operand select is a mux indexed by row/col/k on the latched registers. The single multiplier feeds the accumulator register.

## Test plan
All cases use default parameters unless stated.
1. Q = K = 0x0100 (1.0) everywhere, s_ready=1 → 64 scores of 0x0400 in row-major order. First s_valid 5 cycles after start. s_last on (7,7). Last handshake at cycle 320; done pulses once in cycle 321. sat_flag=0.
2. Rounding: Q[0][0]=0x0001, K[0][0]=0x0080, rest 0 → S[0][0]=0x0001. Q[0][0]=0xFFFF, K[0][0]=0x0080 → S[0][0]=0x0000. All other scores 0x0000.
3. Saturation: Q = K = 0x7FFF → every score 0x7FFF and sat_flag=1. Q=0x8000, K=0x7FFF → every score 0x8000. A following accepted start clears sat_flag.
4. Backpressure: s_ready=0 for 10 cycles while (2,3) is presented → s_valid, s_data, s_row=2 and s_col=3 held stable. After release the next score arrives 5 cycles later. Total grows by exactly 10 cycles.
5. Control: start pulsed during busy is ignored, and the score count stays 64. rst asserted mid-stream at score 20 → all outputs 0 immediately. A new start then yields the full 64 scores from (0,0).
6. SCALE_SHIFT=1, TOKEN_DIM=8, TOKEN_NUM=4, all 1.0 → 16 scores of 0x0400. Period 9 cycles.
